// File: rtl/game_ctrl_if.sv
// Shared state encoding and the sequencer's bus to the display controller.
// The package lives here so it compiles ahead of the interface that uses it.
package game_types;
  typedef enum logic [3:0] {
    S_IDLE,
    S_SET_D3,
    S_SET_D2,
    S_SET_D1,
    S_SET_D0,
    S_GUESS_D3,
    S_GUESS_D2,
    S_GUESS_D1,
    S_GUESS_D0,
    S_SHOW_RESULT,
    S_WIN,
    S_LOSE
  } state_t;
endpackage

interface game_ctrl_if;
  import game_types::*;

  logic [3:0] sw;
  logic       key_confirm;
  logic       key_start;
  state_t     state;
  logic [3:0] target [3:0];
  logic [3:0] guess  [3:0];
  logic [3:0] candidate;
  logic       sw_valid;
  logic [2:0] chances;
  logic       blink_on;
  logic [2:0] bulls;

  modport master (
    input  sw, key_confirm, key_start,
    output state, target, guess, candidate, sw_valid, chances, blink_on, bulls
  );

  modport slave (
    output sw, key_confirm, key_start,
    input  state, target, guess, candidate, sw_valid, chances, blink_on, bulls
  );
endinterface

// File: rtl/game_ctrl.sv
// Bulls-and-Cows master sequencer: code entry, guess rounds, scoring, timed
// result display and blink phase for the active digit.
module game_ctrl
  import game_types::*;
#(
  parameter int unsigned BLINK_DIV     = 25_000_000,
  parameter int unsigned RESULT_CYCLES = 150_000_000,
  parameter int unsigned MAX_CHANCES   = 5
) (
  input  logic            clk,
  input  logic            rst,
  game_ctrl_if.master     bus
);

  localparam int unsigned BlinkW  = $clog2(BLINK_DIV);
  localparam int unsigned ResultW = $clog2(RESULT_CYCLES);
  localparam logic [BlinkW-1:0]  BlinkLast  = BlinkW'(BLINK_DIV - 1);
  localparam logic [ResultW-1:0] ResultLast = ResultW'(RESULT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [3:0]         target_q [3:0];
  logic [3:0]         target_d [3:0];
  logic [3:0]         guess_q  [3:0];
  logic [3:0]         guess_d  [3:0];
  logic [2:0]         chances_q, chances_d;
  logic [2:0]         bulls_q, bulls_d;
  logic [BlinkW-1:0]  blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;
  logic [ResultW-1:0] res_cnt_q, res_cnt_d;

  logic       entry_set, entry_guess, dup, sw_valid, accept;
  logic [1:0] digit;
  logic [2:0] bulls_calc;

  // Decode which digit (if any) is currently being entered.
  always_comb begin
    entry_set   = 1'b0;
    entry_guess = 1'b0;
    digit       = 2'd0;
    unique case (state_q)
      S_SET_D3:   begin entry_set   = 1'b1; digit = 2'd3; end
      S_SET_D2:   begin entry_set   = 1'b1; digit = 2'd2; end
      S_SET_D1:   begin entry_set   = 1'b1; digit = 2'd1; end
      S_SET_D0:   begin entry_set   = 1'b1; digit = 2'd0; end
      S_GUESS_D3: begin entry_guess = 1'b1; digit = 2'd3; end
      S_GUESS_D2: begin entry_guess = 1'b1; digit = 2'd2; end
      S_GUESS_D1: begin entry_guess = 1'b1; digit = 2'd1; end
      S_GUESS_D0: begin entry_guess = 1'b1; digit = 2'd0; end
      default: ;
    endcase
  end

  // Only digits to the left of the active one are already confirmed.
  always_comb begin
    dup = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j > int'(digit)) begin
        if (entry_set && bus.sw == target_q[j]) dup = 1'b1;
        if (entry_guess && bus.sw == guess_q[j]) dup = 1'b1;
      end
    end
    sw_valid = (entry_set | entry_guess) && (bus.sw <= 4'd9) && !dup;
    accept   = bus.key_confirm & sw_valid;
  end

  // Score uses the digit being confirmed right now in place of guess[0].
  always_comb begin
    bulls_calc = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (((i == 0) ? bus.sw : guess_q[i]) == target_q[i]) bulls_calc = bulls_calc + 3'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    guess_d   = guess_q;
    chances_d = chances_q;
    bulls_d   = bulls_q;
    res_cnt_d = res_cnt_q;

    if (accept && entry_set)   target_d[digit] = bus.sw;
    if (accept && entry_guess) guess_d[digit]  = bus.sw;

    unique case (state_q)
      S_IDLE:     if (bus.key_start) state_d = S_SET_D3;
      S_SET_D3:   if (accept) state_d = S_SET_D2;
      S_SET_D2:   if (accept) state_d = S_SET_D1;
      S_SET_D1:   if (accept) state_d = S_SET_D0;
      S_SET_D0: begin
        if (accept) begin
          chances_d = 3'(MAX_CHANCES);
          guess_d   = '{default: 4'd0};
          state_d   = S_GUESS_D3;
        end
      end
      S_GUESS_D3: if (accept) state_d = S_GUESS_D2;
      S_GUESS_D2: if (accept) state_d = S_GUESS_D1;
      S_GUESS_D1: if (accept) state_d = S_GUESS_D0;
      S_GUESS_D0: begin
        if (accept) begin
          chances_d = chances_q - 3'd1;
          bulls_d   = bulls_calc;
          res_cnt_d = '0;
          state_d   = S_SHOW_RESULT;
        end
      end
      S_SHOW_RESULT: begin
        if (res_cnt_q == ResultLast) begin
          if (bulls_q == 3'd4) begin
            state_d = S_WIN;
          end else if (chances_q == 3'd0) begin
            state_d = S_LOSE;
          end else begin
            guess_d = '{default: 4'd0};
            state_d = S_GUESS_D3;
          end
        end else begin
          res_cnt_d = res_cnt_q + 1'b1;
        end
      end
      S_WIN, S_LOSE: if (bus.key_start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Restart the blink phase visible whenever the state changes.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (state_d != state_q) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      target_q    <= '{default: 4'd0};
      guess_q     <= '{default: 4'd0};
      chances_q   <= 3'd0;
      bulls_q     <= 3'd0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      res_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      guess_q     <= guess_d;
      chances_q   <= chances_d;
      bulls_q     <= bulls_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      res_cnt_q   <= res_cnt_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.target    = target_q;
  assign bus.guess     = guess_q;
  assign bus.candidate = bus.sw;
  assign bus.sw_valid  = sw_valid;
  assign bus.chances   = chances_q;
  assign bus.blink_on  = blink_on_q;
  assign bus.bulls     = bulls_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with short blink/result periods.
module tb_game_ctrl;
  import game_types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  game_ctrl_if gi ();

  game_ctrl #(
    .BLINK_DIV    (4),
    .RESULT_CYCLES(8),
    .MAX_CHANCES  (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(gi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] tgt();
    return {gi.target[3], gi.target[2], gi.target[1], gi.target[0]};
  endfunction

  function automatic logic [15:0] gss();
    return {gi.guess[3], gi.guess[2], gi.guess[1], gi.guess[0]};
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic confirm(input logic [3:0] d);
    gi.sw          = d;
    gi.key_confirm = 1'b1;
    tick();
    gi.key_confirm = 1'b0;
  endtask

  task automatic start_pulse();
    gi.key_start = 1'b1;
    tick();
    gi.key_start = 1'b0;
  endtask

  task automatic enter4(input logic [15:0] code);
    confirm(code[15:12]);
    confirm(code[11:8]);
    confirm(code[7:4]);
    confirm(code[3:0]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    gi.sw          = 4'd0;
    gi.key_confirm = 1'b0;
    gi.key_start   = 1'b0;
    tick();
    do_reset();

    check("rst_state", 32'(gi.state), 32'(S_IDLE));
    check("rst_chances", 32'(gi.chances), 32'd0);
    check("rst_bulls", 32'(gi.bulls), 32'd0);
    check("rst_blink", 32'(gi.blink_on), 32'd1);
    check("rst_target", 32'(tgt()), 32'h0000);
    gi.sw = 4'd3;
    #1;
    check("idle_sw_valid", 32'(gi.sw_valid), 32'd0);
    check("candidate", 32'(gi.candidate), 32'd3);

    // Duplicate / range rejection during code entry
    start_pulse();
    check("start_state", 32'(gi.state), 32'(S_SET_D3));
    confirm(4'd7);
    check("set_d2_state", 32'(gi.state), 32'(S_SET_D2));
    gi.sw = 4'd7;
    #1;
    check("dup_invalid", 32'(gi.sw_valid), 32'd0);
    confirm(4'd7);
    check("dup_ignored", 32'(gi.state), 32'(S_SET_D2));
    check("dup_target", 32'(tgt()), 32'h7000);
    gi.sw = 4'hA;
    #1;
    check("range_invalid", 32'(gi.sw_valid), 32'd0);
    gi.sw = 4'd3;
    #1;
    check("ok_valid", 32'(gi.sw_valid), 32'd1);
    confirm(4'd3);
    check("set_d1_state", 32'(gi.state), 32'(S_SET_D1));

    // Setup 1234
    do_reset();
    start_pulse();
    enter4(16'h1234);
    check("setup_state", 32'(gi.state), 32'(S_GUESS_D3));
    check("setup_target", 32'(tgt()), 32'h1234);
    check("setup_chances", 32'(gi.chances), 32'd5);
    check("setup_blink", 32'(gi.blink_on), 32'd1);
    repeat (3) tick();
    check("blink_hold", 32'(gi.blink_on), 32'd1);
    tick();
    check("blink_toggle", 32'(gi.blink_on), 32'd0);

    // Scoring 1243
    confirm(4'd1);
    gi.sw = 4'd1;
    #1;
    check("guess_dup_invalid", 32'(gi.sw_valid), 32'd0);
    confirm(4'd2);
    confirm(4'd4);
    check("guess_d0_blink", 32'(gi.blink_on), 32'd1);
    confirm(4'd3);
    check("score_state", 32'(gi.state), 32'(S_SHOW_RESULT));
    check("score_bulls", 32'(gi.bulls), 32'd2);
    check("score_chances", 32'(gi.chances), 32'd4);
    check("score_guess", 32'(gss()), 32'h1243);
    repeat (7) tick();
    check("show_hold", 32'(gi.state), 32'(S_SHOW_RESULT));
    tick();
    check("next_round", 32'(gi.state), 32'(S_GUESS_D3));
    check("guess_cleared", 32'(gss()), 32'h0000);

    // Win
    enter4(16'h1234);
    check("win_bulls", 32'(gi.bulls), 32'd4);
    check("win_chances", 32'(gi.chances), 32'd3);
    repeat (8) tick();
    check("win_state", 32'(gi.state), 32'(S_WIN));
    check("win_target_hold", 32'(tgt()), 32'h1234);
    start_pulse();
    check("win_to_idle", 32'(gi.state), 32'(S_IDLE));

    // Loss, with key presses during the result display
    start_pulse();
    enter4(16'h1234);
    check("loss_setup", 32'(gi.chances), 32'd5);
    for (int r = 0; r < 5; r++) begin
      enter4(16'h5678);
      check("loss_chances", 32'(gi.chances), 32'(4 - r));
      check("loss_bulls", 32'(gi.bulls), 32'd0);
      gi.sw          = 4'd9;
      gi.key_confirm = 1'b1;
      gi.key_start   = 1'b1;
      repeat (7) tick();
      check("loss_show_ignore", 32'(gi.state), 32'(S_SHOW_RESULT));
      tick();
      gi.key_confirm = 1'b0;
      gi.key_start   = 1'b0;
      if (r < 4) check("loss_round", 32'(gi.state), 32'(S_GUESS_D3));
      else       check("loss_state", 32'(gi.state), 32'(S_LOSE));
    end
    check("loss_guess_hold", 32'(gss()), 32'h5678);

    // Reset mid-result
    start_pulse();
    start_pulse();
    enter4(16'h1234);
    enter4(16'h1243);
    check("mid_show", 32'(gi.state), 32'(S_SHOW_RESULT));
    repeat (2) tick();
    do_reset();
    check("midrst_state", 32'(gi.state), 32'(S_IDLE));
    check("midrst_chances", 32'(gi.chances), 32'd0);
    check("midrst_bulls", 32'(gi.bulls), 32'd0);
    check("midrst_target", 32'(tgt()), 32'h0000);
    check("midrst_guess", 32'(gss()), 32'h0000);
    check("midrst_blink", 32'(gi.blink_on), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Master sequencer for the 4-digit Bulls-and-Cows game. Drives the state, target, guess, candidate, sw_valid, chances and blink_on inputs of the display controller.
- Player 1 enters a secret code of 4 distinct digits on SW[3:0] via a confirm key. Player 2 then has MAX_CHANCES guesses, each scored and shown for a fixed time before the next round, a win or a loss.

Parameters:
- BLINK_DIV, 25_000_000, clock cycles per blink half-period (0.5 s at 50 MHz).
- RESULT_CYCLES, 150_000_000, cycles spent in S_SHOW_RESULT (3 s at 50 MHz).
- MAX_CHANCES, 5, guesses per game; must be 1..7.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sw  in  4  raw digit switches.
- key_confirm  in  1  one-cycle pulse, already debounced and edge-detected upstream.
- key_start  in  1  one-cycle pulse, already debounced and edge-detected upstream.
- state  out  state_t  current FSM state (game_types).
- target  out  4x4 unpacked [3:0]  secret digits; [3] is leftmost.
- guess  out  4x4 unpacked [3:0]  current guess digits.
- candidate  out  4  equals sw (combinational pass-through).
- sw_valid  out  1  candidate is acceptable for the digit currently being entered.
- chances  out  3  remaining guesses.
- blink_on  out  1  blink phase.
- bulls  out  3  exact-position matches of the last scored guess, 0..4.

Behaviour:
- Reset values (rst sampled high at a clock edge, from any state, including mid-entry or mid-result): state=S_IDLE, target and guess all 4'd0, chances=0, bulls=0, blink counter=0, blink_on=1, result timer=0.
- sw_valid (combinational):
  - Requires sw<=9.
  - In S_SET_Dk, sw must also differ from every already-confirmed target[j] with j>k.
  - In S_GUESS_Dk, sw must also differ from every confirmed guess[j] with j>k.
  - Outside SET/GUESS states, sw_valid=0.
- Accepted confirm = key_confirm & sw_valid in a SET/GUESS state. A confirm with sw_valid=0 is ignored: no state or data change.
- Transitions (all registered, 1-cycle latency from the accepted pulse):
  - S_IDLE: key_start -> S_SET_D3.
  - S_SET_D3..D1: accepted confirm writes target[k]=sw -> S_SET_D(k-1).
  - S_SET_D0: accepted confirm writes target[0]=sw; chances=MAX_CHANCES; guess cleared to 0 -> S_GUESS_D3.
  - S_GUESS_D3..D1: accepted confirm writes guess[k]=sw -> S_GUESS_D(k-1).
  - S_GUESS_D0: accepted confirm writes guess[0]=sw; chances decrements by 1; bulls is loaded with the popcount of guess[i]==target[i], using the new guess[0]; result timer is cleared -> S_SHOW_RESULT.
  - S_SHOW_RESULT: timer counts 0..RESULT_CYCLES-1. On the cycle it equals RESULT_CYCLES-1, exactly one of:
    - bulls==4 -> S_WIN.
    - else chances==0 -> S_LOSE.
    - else guess cleared to 0 -> S_GUESS_D3.
    - key_confirm and key_start are ignored in this state.
  - S_WIN, S_LOSE: key_start -> S_IDLE. Target, guess, chances and bulls hold until the next S_SET_D0 / S_GUESS_D0 update.
- key_start is ignored in SET/GUESS/SHOW_RESULT. key_confirm is ignored in IDLE/WIN/LOSE. If both pulse in the same cycle, each is evaluated only where it is legal, so no conflict arises.
- Blink:
  - Counter runs 0..BLINK_DIV-1; blink_on toggles on wrap.
  - On any state change the counter clears and blink_on is forced to 1 on the same edge, so a newly active digit is visible immediately.
- Widths:
  - chances never underflows; it is only decremented from values >=1 in GUESS_D0.
  - Counter widths are $clog2 of their parameters; RESULT_CYCLES and BLINK_DIV must be >=2.

Test Plan (bench uses BLINK_DIV=4, RESULT_CYCLES=8, MAX_CHANCES=5):
- Setup: rst, key_start, then confirm sw=1,2,3,4 -> state S_GUESS_D3, target={1,2,3,4}, chances=5, blink_on=1 on the entry cycle.
- Duplicate/range rejection: in S_SET_D2 with target[3]=7, set sw=7 -> sw_valid=0, confirm leaves state S_SET_D2. sw=4'hA -> sw_valid=0. sw=3 -> sw_valid=1, confirm advances to S_SET_D1.
- Scoring: target 1234, guess 1243 -> S_SHOW_RESULT, bulls=2, chances=4. After 8 cycles -> S_GUESS_D3 with guess=0000.
- Win: guess 1234 -> bulls=4 -> S_WIN after 8 cycles. key_start -> S_IDLE.
- Loss: five wrong guesses (5678) -> chances 4,3,2,1,0, then S_LOSE. Confirm pulses during S_SHOW_RESULT have no effect.
- Reset mid-result: assert rst in cycle 3 of S_SHOW_RESULT -> next cycle state=S_IDLE, chances=0, bulls=0, target/guess=0, blink_on=1.
